// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_pkg
// Description : Shared constants, FSM state type and helpers for the
//               16-way round-robin mux arbiter.
// Contents    : N     - number of requesters (16)
//               SELW  - select width (4)
//               state_t   - arbiter FSM state {IDLE, GRANT}
//               onehot16  - select index -> one-hot 16-bit grant
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_pkg;

    localparam int N    = 16;
    localparam int SELW = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot16(input logic [SELW-1:0] sel);
        logic [N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick16
// Description : Combinational round-robin search. Returns the first set bit
//               of i_req at or after position (i_base + 1), wrapping 15 -> 0.
// Ports       : i_req   [15:0] - candidate request vector (already masked)
//               i_base  [3:0]  - index the search starts just after
//               o_idx   [3:0]  - winning index (don't-care when !o_found)
//               o_found        - at least one candidate was set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick16
    import rr_mux_pkg::*;
(
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_base,
    output logic [SELW-1:0] o_idx,
    output logic            o_found
);

    logic [SELW-1:0] w_start;
    logic [N-1:0]    w_rot;
    logic [SELW-1:0] w_off;

    // Rotate the request vector so that position w_start lands at bit 0;
    // a plain lowest-set-bit encoder then yields the round-robin winner.
    always_comb begin
        w_start = i_base + 4'd1;
        w_rot   = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = i_req[w_start + k[SELW-1:0]];
        end
    end

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k[SELW-1:0];
            end
        end
    end

    // Undo the rotation; the 4-bit add wraps modulo 16 naturally.
    assign o_idx   = w_start + w_off;
    assign o_found = |w_rot;

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbiter sharing one 16:1 mux among 16 requesters.
//               Drives the mux select and a one-hot grant, and hands the
//               selected channel to one consumer over valid/ready.
// Ports       : clk            - clock, all state on the rising edge
//               reset          - synchronous active-high reset
//               req      [15:0]- request lines
//               ready          - consumer accepts current selection
//               sel      [3:0] - registered mux select
//               gnt      [15:0]- registered one-hot grant (zero when idle)
//               valid          - mux output owned by requester sel
//               last_sel [3:0] - index of the last completed transfer
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
    import rr_mux_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            ready,
    output logic [SELW-1:0] sel,
    output logic [N-1:0]    gnt,
    output logic            valid,
    output logic [SELW-1:0] last_sel
);

    state_t          r_state;
    logic [SELW-1:0] r_sel;
    logic [N-1:0]    r_gnt;
    logic            r_valid;
    logic [SELW-1:0] r_last_sel;

    state_t          w_state_nx;
    logic [SELW-1:0] w_sel_nx;
    logic [N-1:0]    w_gnt_nx;
    logic            w_valid_nx;
    logic [SELW-1:0] w_last_sel_nx;

    logic [N-1:0]    w_mask;
    logic [SELW-1:0] w_base;
    logic [SELW-1:0] w_pick_idx;
    logic            w_pick_found;

    // A single search unit serves both states. In GRANT the current holder
    // is masked out so back-to-back transfers rotate, and the search starts
    // after the holder that is completing; in IDLE it starts after the last
    // completed transfer with every requester eligible.
    assign w_mask = (r_state == GRANT) ? ~r_gnt : {N{1'b1}};
    assign w_base = (r_state == GRANT) ? r_sel  : r_last_sel;

    rr_pick16 u_pick (
        .i_req   (req & w_mask),
        .i_base  (w_base),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_gnt      <= '0;
            r_valid    <= 1'b0;
            r_last_sel <= 4'd15;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_gnt      <= w_gnt_nx;
            r_valid    <= w_valid_nx;
            r_last_sel <= w_last_sel_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_sel_nx      = r_sel;
        w_gnt_nx      = r_gnt;
        w_valid_nx    = r_valid;
        w_last_sel_nx = r_last_sel;

        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_sel_nx   = w_pick_idx;
                    w_gnt_nx   = onehot16(w_pick_idx);
                    w_valid_nx = 1'b1;
                    w_state_nx = GRANT;
                end
            end
            GRANT: begin
                // Without ready the grant is frozen; req changes are ignored.
                if (ready) begin
                    w_last_sel_nx = r_sel;
                    if (w_pick_found) begin
                        w_sel_nx = w_pick_idx;
                        w_gnt_nx = onehot16(w_pick_idx);
                    end else begin
                        // sel is left pointing at the finished holder.
                        w_gnt_nx   = '0;
                        w_valid_nx = 1'b0;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_gnt_nx   = '0;
                w_valid_nx = 1'b0;
            end
        endcase
    end

    assign sel      = r_sel;
    assign gnt      = r_gnt;
    assign valid    = r_valid;
    assign last_sel = r_last_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Directed self-checking bench for rr_mux_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        ready;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        valid;
    logic [3:0]  last_sel;

    int n_checks;
    int n_fail;

    rr_mux_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ready    (ready),
        .sel      (sel),
        .gnt      (gnt),
        .valid    (valid),
        .last_sel (last_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_sel,
                             input logic [15:0] e_gnt, input logic e_valid);
        check({tag, ".sel"},   32'(sel),   32'(e_sel));
        check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
    endtask

    // Invariant monitor, sampled mid-cycle.
    logic [3:0] m_prev_sel;
    logic       m_prev_hold;
    initial m_prev_hold = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b0) begin
            check("inv.idle_gnt_zero", 32'(gnt), 32'h0);
        end else begin
            check("inv.onehot",   32'($onehot(gnt)), 32'd1);
            check("inv.gnt_sel",  32'(gnt[sel]),     32'd1);
        end
        if (m_prev_hold) begin
            check("inv.sel_stable", 32'(sel), 32'(m_prev_sel));
        end
        m_prev_sel  = sel;
        m_prev_hold = valid && !ready && !reset;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        req   = '0;
        ready = 1'b0;

        // ---- Reset state
        tick();
        check_out("rst", 4'd0, 16'h0000, 1'b0);
        check("rst.last_sel", 32'(last_sel), 32'd15);

        // ---- Single requester 4: grant, release, grant again
        reset = 1'b0; req = 16'h0010; ready = 1'b1;
        tick();
        check_out("r4.g1", 4'd4, 16'h0010, 1'b1);
        tick();
        check_out("r4.idle", 4'd4, 16'h0000, 1'b0);
        check("r4.last_sel", 32'(last_sel), 32'd4);
        tick();
        check_out("r4.g2", 4'd4, 16'h0010, 1'b1);

        // ---- All requesting, fairness over 20 transfers
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 16'hFFFF; ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_out($sformatf("rr%0d", i), 4'(i % 16), 16'(1 << (i % 16)), 1'b1);
        end

        // ---- Wrap-around with requesters 15 and 0, last_sel set to 14
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 16'h4000; ready = 1'b1;
        tick();
        check_out("wr.g14", 4'd14, 16'h4000, 1'b1);
        req = 16'h8001;
        tick();
        check_out("wr.g15", 4'd15, 16'h8000, 1'b1);
        check("wr.last14", 32'(last_sel), 32'd14);
        tick();
        check_out("wr.g0", 4'd0, 16'h0001, 1'b1);
        check("wr.last15", 32'(last_sel), 32'd15);
        tick();
        check_out("wr.g15b", 4'd15, 16'h8000, 1'b1);

        // ---- Grant 6 held under ready=0 while req changes
        reset = 1'b1; req = '0; ready = 1'b0; tick();
        reset = 1'b0; req = 16'h0040;
        tick();
        check_out("hold.g6", 4'd6, 16'h0040, 1'b1);
        req = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("hold%0d", i), 4'd6, 16'h0040, 1'b1);
        end
        ready = 1'b1;
        tick();
        check_out("hold.g2", 4'd2, 16'h0004, 1'b1);
        check("hold.last6", 32'(last_sel), 32'd6);

        // ---- Requesters 9 and 11 with last_sel = 9
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 16'h0200; ready = 1'b1;
        tick();
        check_out("p.g9a", 4'd9, 16'h0200, 1'b1);
        req = 16'h0A00;
        tick();
        check_out("p.g11", 4'd11, 16'h0800, 1'b1);
        check("p.last9", 32'(last_sel), 32'd9);
        tick();
        check_out("p.g9b", 4'd9, 16'h0200, 1'b1);
        req = 16'h0000;
        tick();
        check_out("p.idle", 4'd9, 16'h0000, 1'b0);
        check("p.last9b", 32'(last_sel), 32'd9);

        // ---- Reset mid-grant overrides ready
        reset = 1'b1; req = '0; tick();
        reset = 1'b0; req = 16'h0080; ready = 1'b1;
        tick();
        check_out("mr.g7", 4'd7, 16'h0080, 1'b1);
        reset = 1'b1;
        tick();
        check_out("mr.rst", 4'd0, 16'h0000, 1'b0);
        check("mr.last15", 32'(last_sel), 32'd15);
        reset = 1'b0;
        tick();
        check_out("mr.g7b", 4'd7, 16'h0080, 1'b1);

        ready = 1'b0; req = '0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one mux16_to_1 datapath among 16 requesters.
- Drives the 4-bit select of the 16:1 mux and a one-hot grant vector.
- Presents the selected channel to a single downstream consumer through a valid/ready handshake.
- Sits directly in front of the mux16_to_1 instance. Its sel output connects to the mux sel input, and requester i drives mux in[i].

Parameters:
- N, 16, number of requesters; fixed at 16 to match the mux width.
- SELW, 4, select width, log2(N).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  16  request lines; req[i] high means requester i wants the mux.
- ready  input  1  downstream accepts the current selection this cycle.
- sel  output  4  registered mux select; index of the granted requester.
- gnt  output  16  registered one-hot grant; gnt[i] = (sel == i) while valid.
- valid  output  1  registered; mux output is owned by requester sel.
- last_sel  output  4  index of the most recently completed transfer; round-robin pointer base.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset). There are no asynchronous paths.
- Reset values: sel=0, gnt=0, valid=0, last_sel=15, state=IDLE. With last_sel=15, the first search starts at requester 0.
- Two-state FSM: IDLE, GRANT.
- Pick function: returns the first index j with req_m[j]=1, searching (base+1), (base+2), ... mod 16, wrapping 15->0. It also returns a found flag.
- IDLE:
  - If |req, compute pick(req, last_sel). Next edge: sel=j, gnt=one-hot(j), valid=1, state=GRANT.
  - If req==0, remain IDLE with all outputs held at their idle values.
  - Latency: req sampled high at edge k gives valid high after edge k (one cycle).
- GRANT, ready=0:
  - Hold sel, gnt and valid unchanged.
  - Changes on req are ignored. A requester dropping req does not revoke the grant; requesters must hold their data until the transfer completes.
- GRANT, ready=1 (transfer completes at this edge):
  - last_sel <= sel.
  - Compute pick(req & ~gnt, sel). The current holder is masked out for the back-to-back choice.
  - If found: sel=j, gnt=one-hot(j), valid stays 1, state stays GRANT. This gives one transfer per cycle under continuous load.
  - If not found: valid=0, gnt=0, state=IDLE. sel holds its value. The masked holder may win again in the following IDLE cycle.
- Fairness: with all 16 requesting and ready tied high, grants cycle 0,1,...,15,0,... with no repeats within any 16 consecutive transfers.
- Wrap-around: a completed transfer at sel=15 makes the next search start at 0.
- A single requester that is always asserted gets a grant every other cycle: GRANT, IDLE, GRANT, and so on.
- Reset asserted mid-GRANT: at the next edge all outputs return to their reset values. The in-flight transfer counts as not accepted, even if ready=1 in that same cycle, and last_sel resets to 15.
- reset has priority over every other input.
- Invariants checked by assertions:
  - valid==0 implies gnt==0.
  - valid==1 implies $onehot(gnt) and gnt[sel]==1.
  - sel is stable while valid && !ready.

Decomposition:
- Package rr_mux_pkg:
  - Constants N=16 and SELW=4.
  - State enum {IDLE, GRANT}.
  - Function onehot16(sel).
- Sub-module rr_pick16 (purely combinational):
  - Inputs: req[15:0], base[3:0].
  - Outputs: idx[3:0], found.
  - Implementation: rotate req right by base+1, priority-encode the lowest set bit, then add base+1 mod 16.
- One instance serves IDLE (mask = all ones) and GRANT (mask = ~gnt). The mask is selected from the state.
- The top level holds the FSM and registers.

Test Plan:
- Reset then req=16'h0010, ready=1 -> after one edge, valid=1, sel=4, gnt=16'h0010. Next edge: last_sel=4, valid=0 (requester masked). The cycle after that: grant 4 again.
- req=16'hFFFF, ready=1 for 20 cycles from reset -> sel sequence is 0,1,...,15,0,1,2,3 with valid continuously 1 after the first cycle.
- req=16'h8001, last_sel=14, ready=1 -> grants 15 then 0 then 15 (wrap-around verified).
- Grant on sel=6 with ready=0 for 5 cycles while req[6] drops and req[2] rises -> sel, gnt and valid stay frozen at 6. Raising ready then moves to sel=2 at the next edge.
- req=16'h0A00 (requesters 9 and 11), last_sel=9 -> first grant 11, then 9 back-to-back, then IDLE if req has cleared.
- reset=1 while valid=1, sel=7, ready=1 -> next edge: valid=0, gnt=0, sel=0, last_sel=15. After reset is released with req=16'h0080, sel=7 is granted one cycle later.
